capture_scheduler: RTL and testbench

- Arbitrates two requesters sharing one WIDTH-bit capture register bank.
- Produces the one-cycle capture strobe, latched data, owner tag and per-requester acknowledge.
- Enforces a programmable hold window after every capture, so downstream logic sees stable data.
- Sits in front of the shared flip-flop bank and replaces the free-running external capture clock with a scheduled strobe.

---
 rtl/capture_scheduler.sv | 129 ++++++++++++
 tb/tb_capture_scheduler.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/capture_scheduler.sv
// Two-requester capture scheduler: grants one shared WIDTH-bit bank and enforces a hold window after each capture.
// Optional build macro CAPTURE_SCHED_FIXED_PRIO_EN selects fixed priority (A wins ties); default is round-robin.
module capture_scheduler #(
  parameter int WIDTH       = 6,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic             cap_stb,
  output logic [WIDTH-1:0] q,
  output logic             owner,
  output logic             busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  generate
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > (1 << CNT_W) - 1) begin : g_bad_hold_cfg
      $error("capture_scheduler: HOLD_CYCLES=%0d does not fit a %0d-bit hold counter", HOLD_CYCLES, CNT_W);
    end
  endgenerate

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             owner_q, owner_d;
  logic             busy_q, busy_d;
  logic             ack_a_q, ack_a_d;
  logic             ack_b_q, ack_b_d;
  logic             cap_stb_q, cap_stb_d;
  logic             grant_a, grant_b;

`ifdef CAPTURE_SCHED_FIXED_PRIO_EN
  always_comb begin
    grant_a = req_a;
    grant_b = req_b & ~req_a;
  end
`else
  // ptr_q high means B was granted last, so A takes the next tie.
  logic ptr_q, ptr_d;

  always_comb begin
    grant_a = req_a & (~req_b | ptr_q);
    grant_b = req_b & (~req_a | ~ptr_q);
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && (req_a || req_b)) ptr_d = grant_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b1;
    else        ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    ack_a_d   = 1'b0;
    ack_b_d   = 1'b0;
    cap_stb_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_a || grant_b) begin
          q_d       = grant_b ? data_b : data_a;
          owner_d   = grant_b;
          ack_a_d   = grant_a;
          ack_b_d   = grant_b;
          cap_stb_d = 1'b1;
          cnt_d     = CNT_W'(HOLD_CYCLES - 1);
          busy_d    = 1'b1;
          state_d   = ST_HOLD;
        end
      end
      default: begin
        // Counter reaching zero marks the last hold cycle; release on the following edge.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      q_q       <= '0;
      owner_q   <= 1'b0;
      busy_q    <= 1'b0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      cap_stb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      cap_stb_q <= cap_stb_d;
    end
  end

  assign ack_a   = ack_a_q;
  assign ack_b   = ack_b_q;
  assign cap_stb = cap_stb_q;
  assign q       = q_q;
  assign owner   = owner_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_capture_scheduler.sv
// Testbench for capture_scheduler: directed scenarios then randomized requesters against a transaction-level model.
module tb_capture_scheduler;

  localparam int WIDTH = 6;
  localparam int HOLD  = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_a = 1'b0, req_b = 1'b0;
  logic [WIDTH-1:0] data_a = '0, data_b = '0;
  logic             ack_a, ack_b, cap_stb, owner, busy;
  logic [WIDTH-1:0] q;

  capture_scheduler #(.WIDTH(WIDTH), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
    .ack_a(ack_a), .ack_b(ack_b), .cap_stb(cap_stb),
    .q(q), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_stb_cyc = -1;

  // Model: cycles of hold still to elapse, last winner, and what the bank should show.
  int               m_hold = 0;
  logic             m_last_b = 1'b1;
  logic [WIDTH-1:0] m_q = '0;
  logic             m_owner = 1'b0;
  logic             e_ack_a = 1'b0, e_ack_b = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":ack_a"}, 32'(ack_a), 32'(e_ack_a));
    chk({tag, ":ack_b"}, 32'(ack_b), 32'(e_ack_b));
    chk({tag, ":cap_stb"}, 32'(cap_stb), 32'(e_ack_a | e_ack_b));
    chk({tag, ":q"}, 32'(q), 32'(m_q));
    chk({tag, ":owner"}, 32'(owner), 32'(m_owner));
    chk({tag, ":busy"}, 32'(busy), 32'(m_hold > 0));
  endtask

  task automatic model_reset();
    m_hold = 0; m_last_b = 1'b1; m_q = '0; m_owner = 1'b0;
    e_ack_a = 1'b0; e_ack_b = 1'b0;
  endtask

  // One clock: decide the model outcome from the inputs seen at the edge, then compare just after it.
  task automatic tick(input string tag);
    logic ga, gb;
    ga = 1'b0; gb = 1'b0;
    if (m_hold == 0) begin
      if (req_a && req_b) begin
`ifdef CAPTURE_SCHED_FIXED_PRIO_EN
        ga = 1'b1;
`else
        if (m_last_b) ga = 1'b1; else gb = 1'b1;
`endif
      end else if (req_a) ga = 1'b1;
      else if (req_b) gb = 1'b1;
    end else begin
      m_hold--;
    end
    if (ga || gb) begin
      m_q = gb ? data_b : data_a;
      m_owner = gb;
      m_last_b = gb;
      m_hold = HOLD;
    end
    e_ack_a = ga; e_ack_b = gb;
    @(posedge clk); #1;
    cyc++;
    check_all(tag);
    if (cap_stb === 1'b1) begin
      if (last_stb_cyc >= 0) chk({tag, ":stb_spacing_ok"}, 32'((cyc - last_stb_cyc) >= HOLD + 1), 32'd1);
      last_stb_cyc = cyc;
    end
  endtask

  // Async reset between edges: outputs must clear before any clock edge arrives.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all({tag, ":async"});
    @(posedge clk); #1;
    cyc++;
    check_all({tag, ":held"});
    #3 rst_n = 1'b1;
    last_stb_cyc = -1;
  endtask

  initial begin
    // Power-on reset
    #3;
    model_reset();
    check_all("por");
    @(posedge clk); #1;
    cyc++;
    rst_n = 1'b1;
    tick("idle");

    // Single request from A
    req_a = 1'b1; data_a = 6'h15;
    tick("single_grant");
    chk("single_q", 32'(q), 32'h15);
    req_a = 1'b0;
    for (int i = 0; i < 6; i++) tick("single_hold");

    // Request from B only during hold cycles 1-3
    req_a = 1'b1; data_a = 6'h07;
    tick("rdh_grant");
    req_a = 1'b0; req_b = 1'b1; data_b = 6'h2B;
    for (int i = 0; i < 3; i++) tick("rdh_hold");
    req_b = 1'b0;
    for (int i = 0; i < 4; i++) tick("rdh_after");
    chk("rdh_q_unchanged", 32'(q), 32'h07);

    // Tie fairness: both held for several captures
    req_a = 1'b1; data_a = 6'h01; req_b = 1'b1; data_b = 6'h3E;
    for (int i = 0; i < 22; i++) tick("tie");
    req_a = 1'b0; req_b = 1'b0;
    for (int i = 0; i < 6; i++) tick("tie_drain");

    // Reset mid-hold, then a capture from B gets the full hold
    req_a = 1'b1; data_a = 6'h33;
    tick("rmh_grant");
    req_a = 1'b0;
    tick("rmh_hold1");
    do_reset("rmh_reset");
    chk("rmh_q_zero", 32'(q), 32'h0);
    req_b = 1'b1; data_b = 6'h0C;
    tick("rmh_b_grant");
    chk("rmh_owner_b", 32'(owner), 32'd1);
    req_b = 1'b0;
    for (int i = 0; i < 6; i++) tick("rmh_hold");

    // Back-to-back from A with req held through the ack
    req_a = 1'b1; data_a = 6'h2A;
    for (int i = 0; i < 12; i++) tick("b2b");
    req_a = 1'b0;
    for (int i = 0; i < 5; i++) tick("b2b_drain");

    // Reset mid-run with data present on A
    req_a = 1'b1; data_a = 6'h2A;
    tick("rst_mid_grant");
    do_reset("rst_mid");
    req_a = 1'b0;
    tick("rst_mid_after");

    // Randomized requesters following the handshake
    for (int i = 0; i < 400; i++) begin
      if (ack_a === 1'b1) begin
        if ($urandom_range(2) != 0) req_a = 1'b0;
      end else if (!req_a) begin
        if ($urandom_range(3) == 0) begin req_a = 1'b1; data_a = WIDTH'($urandom); end
      end else if ($urandom_range(15) == 0) req_a = 1'b0;
      if (ack_b === 1'b1) begin
        if ($urandom_range(2) != 0) req_b = 1'b0;
      end else if (!req_b) begin
        if ($urandom_range(3) == 0) begin req_b = 1'b1; data_b = WIDTH'($urandom); end
      end else if ($urandom_range(15) == 0) req_b = 1'b0;
      if ($urandom_range(99) == 0) do_reset("rand_reset");
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
